// File: rtl/digit_serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// digit_serial_adder_pkg
//   Shared definitions for the digit-serial adder slice: FSM state encodings
//   and the counter-width helper used to size the digit counter.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package digit_serial_adder_pkg;

    // Encodings are fixed so that debug dumps and any external decoders
    // agree on the meaning of the 2-bit state value.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width: enough bits to index NDIG digits, never zero.
    function automatic int cnt_width(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// -----------------------------------------------------------------------------
// digit_serial_adder_if
//   Operand / result handshake bundle for digit_serial_adder.
//   Ports (as seen from the adder, slave modport):
//     in_valid  in   operands a/b/cin valid
//     in_ready  out  adder can accept operands
//     a, b      in   WIDTH-bit operands
//     cin       in   carry-in
//     out_valid out  sum/cout/ovf valid
//     out_ready in   consumer accepts the result
//     sum       out  WIDTH-bit (a+b+cin) mod 2^WIDTH
//     cout      out  carry out of the MSB
//     ovf       out  signed overflow
//   The master modport is the producer/consumer side (testbench or parent).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface digit_serial_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/digit_serial_adder_digit_adder.sv
// -----------------------------------------------------------------------------
// digit_adder
//   Combinational ripple of DIGIT full-adder bit cells; one digit of the
//   digit-serial datapath.
//   Ports:
//     i_a, i_b  in   DIGIT-bit digit operands
//     i_ci      in   carry into bit 0 of the digit
//     o_s       out  DIGIT-bit digit sum
//     o_co      out  carry out of the top bit of the digit
//     o_c_msb   out  carry into the top bit of the digit (for signed overflow)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_ci,
    output logic [DIGIT-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb
);
    // w_c[i] is the carry into bit i; w_c[DIGIT] is the digit carry-out.
    logic [DIGIT:0] w_c;

    assign w_c[0] = i_ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
        assign w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_co    = w_c[DIGIT];
    assign o_c_msb = w_c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// -----------------------------------------------------------------------------
// digit_serial_adder
//   Multi-cycle adder: sum = a + b + cin, computed DIGIT bits per clock,
//   least-significant digit first, with a single carry register between
//   digits. Trades latency (WIDTH/DIGIT cycles) for a DIGIT-bit adder.
//   Ports:
//     clk  in   single clock, all state changes on the rising edge
//     rst  in   synchronous, active-high reset
//     bus  slave modport of digit_serial_adder_if (operand and result
//          valid/ready handshakes, a/b/cin in, sum/cout/ovf out)
//   Flow: IDLE accepts operands -> BUSY walks NDIG digits -> DONE holds the
//   result until out_ready -> IDLE. No accept while DONE, so throughput is
//   one operation per NDIG+2 cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module digit_serial_adder
    import digit_serial_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    digit_serial_adder_if.slave bus
);
    localparam int NDIG = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CW   = cnt_width(NDIG);

    // Reject parameter sets that would leave a partial top digit.
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH ||
        (DIGIT >= 1 && (WIDTH % DIGIT) != 0)) begin : g_bad_params
        $error("digit_serial_adder: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
    end

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;
    logic              r_carry;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic              w_accept;
    logic              w_last;
    logic [DIGIT-1:0]  w_a_dig;
    logic [DIGIT-1:0]  w_b_dig;
    logic [DIGIT-1:0]  w_dig_s;
    logic              w_dig_co;
    logic              w_dig_c_msb;

    assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
    assign w_last   = (r_cnt == CW'(NDIG - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking = here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_next
        // unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_next = ST_BUSY;
            ST_BUSY: if (w_last)        w_state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
            default:                    w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.in_ready  = (r_state == ST_IDLE);
        bus.out_valid = (r_state == ST_DONE);
    end

    // ------------------------------------------------------------------
    // Operand capture
    // ------------------------------------------------------------------
    // NOTE: operand registers carry no reset; they are always written at the
    // handshake before anything reads them, so a reset would only add logic.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= bus.a;
            r_b <= bus.b;
        end
    end

    // Select digit r_cnt of each captured operand.
    always_comb begin
        w_a_dig = '0;
        w_b_dig = '0;
        for (int d = 0; d < NDIG; d++) begin
            if (r_cnt == CW'(d)) begin
                w_a_dig = r_a[d*DIGIT +: DIGIT];
                w_b_dig = r_b[d*DIGIT +: DIGIT];
            end
        end
    end

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .i_a     (w_a_dig),
        .i_b     (w_b_dig),
        .i_ci    (r_carry),
        .o_s     (w_dig_s),
        .o_co    (w_dig_co),
        .o_c_msb (w_dig_c_msb)
    );

    // ------------------------------------------------------------------
    // Counter, carry register and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    for (int d = 0; d < NDIG; d++) begin
                        if (r_cnt == CW'(d)) begin
                            r_sum[d*DIGIT +: DIGIT] <= w_dig_s;
                        end
                    end
                    r_carry <= w_dig_co;
                    if (w_last) begin
                        r_cout <= w_dig_co;
                        // Carry into the MSB differs from carry out of it
                        // exactly when the signed result overflowed.
                        r_ovf  <= w_dig_c_msb ^ w_dig_co;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_digit_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_digit_serial_adder
//   Four adder instances (8/2, 8/8, 8/1, 32/4) share one stimulus bus; 'sel'
//   picks the active one. A reference model computes expected results from
//   plain integer arithmetic when an operand handshake is seen, and one
//   compare process checks every consumed result against it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_digit_serial_adder;

    logic        clk;
    logic        rst;
    int          sel;
    logic        drv_valid;
    logic        drv_ready;
    logic        drv_cin;
    logic [31:0] drv_a;
    logic [31:0] drv_b;

    logic        w_in_ready;
    logic        w_out_valid;
    logic        w_cout;
    logic        w_ovf;
    logic [31:0] w_sum;

    int          n_checks  = 0;
    int          n_err     = 0;
    int          n_push    = 0;
    int          n_pop     = 0;
    int          n_flushed = 0;
    int          n_issued  = 0;
    bit          rnd_on    = 1'b0;
    logic [33:0] exp_q[$];

    // ---------------------------------------------------------------- DUTs
    digit_serial_adder_if #(.WIDTH(8))  if_d2 ();
    digit_serial_adder_if #(.WIDTH(8))  if_d8 ();
    digit_serial_adder_if #(.WIDTH(8))  if_d1 ();
    digit_serial_adder_if #(.WIDTH(32)) if_w32 ();

    assign if_d2.in_valid  = drv_valid && (sel == 0);
    assign if_d2.a         = drv_a[7:0];
    assign if_d2.b         = drv_b[7:0];
    assign if_d2.cin       = drv_cin;
    assign if_d2.out_ready = drv_ready;

    assign if_d8.in_valid  = drv_valid && (sel == 1);
    assign if_d8.a         = drv_a[7:0];
    assign if_d8.b         = drv_b[7:0];
    assign if_d8.cin       = drv_cin;
    assign if_d8.out_ready = drv_ready;

    assign if_d1.in_valid  = drv_valid && (sel == 2);
    assign if_d1.a         = drv_a[7:0];
    assign if_d1.b         = drv_b[7:0];
    assign if_d1.cin       = drv_cin;
    assign if_d1.out_ready = drv_ready;

    assign if_w32.in_valid  = drv_valid && (sel == 3);
    assign if_w32.a         = drv_a;
    assign if_w32.b         = drv_b;
    assign if_w32.cin       = drv_cin;
    assign if_w32.out_ready = drv_ready;

    digit_serial_adder #(.WIDTH(8),  .DIGIT(2)) u_d2  (.clk(clk), .rst(rst), .bus(if_d2.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(8)) u_d8  (.clk(clk), .rst(rst), .bus(if_d8.slave));
    digit_serial_adder #(.WIDTH(8),  .DIGIT(1)) u_d1  (.clk(clk), .rst(rst), .bus(if_d1.slave));
    digit_serial_adder #(.WIDTH(32), .DIGIT(4)) u_w32 (.clk(clk), .rst(rst), .bus(if_w32.slave));

    always_comb begin
        w_in_ready  = if_d2.in_ready;
        w_out_valid = if_d2.out_valid;
        w_cout      = if_d2.cout;
        w_ovf       = if_d2.ovf;
        w_sum       = {24'd0, if_d2.sum};
        case (sel)
            1: begin
                w_in_ready  = if_d8.in_ready;
                w_out_valid = if_d8.out_valid;
                w_cout      = if_d8.cout;
                w_ovf       = if_d8.ovf;
                w_sum       = {24'd0, if_d8.sum};
            end
            2: begin
                w_in_ready  = if_d1.in_ready;
                w_out_valid = if_d1.out_valid;
                w_cout      = if_d1.cout;
                w_ovf       = if_d1.ovf;
                w_sum       = {24'd0, if_d1.sum};
            end
            3: begin
                w_in_ready  = if_w32.in_ready;
                w_out_valid = if_w32.out_valid;
                w_cout      = if_w32.cout;
                w_ovf       = if_w32.ovf;
                w_sum       = if_w32.sum;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------- helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int width_of(input int s);
        return (s == 3) ? 32 : 8;
    endfunction

    // Expected {ovf, cout, sum[31:0]} from integer arithmetic on w-bit values.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic cin);
        longint m, half, ua, ub, full, sa, sb, ss;
        logic [31:0] s;
        logic        co, ov;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        full = ua + ub + longint'(cin);
        s    = 32'(full & m);
        co   = ((full >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sb   = (ub >= half) ? ub - (m + 1) : ub;
        ss   = sa + sb + longint'(cin);
        ov   = (ss >= half) || (ss < -half);
        return {ov, co, s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands, wait for the handshake edge, then scramble the bus to
    // show that operands are only taken at the handshake.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
        int waited = 0;
        drv_a     = a;
        drv_b     = b;
        drv_cin   = cin;
        drv_valid = 1'b1;
        n_issued++;
        while (!w_in_ready && waited < 200) begin
            tick();
            waited++;
        end
        if (!w_in_ready) begin
            check("accept_timeout", 64'(w_in_ready), 64'd1);
            drv_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            drv_valid = 1'b0;
            drv_a     = ~a;
            drv_b     = a ^ b;
            drv_cin   = ~cin;
        end
    endtask

    // Cycles from the handshake edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!w_out_valid && lat < 200);
        if (!w_out_valid) check("result_timeout", 64'(w_out_valid), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] es, input logic eco,
                          input logic eov, input int elat);
        int lat;
        start_op(a, b, cin);
        wait_result(lat);
        check({name, "_latency"}, 64'(lat), 64'(elat));
        check({name, "_value"}, {30'd0, w_ovf, w_cout, w_sum}, {30'd0, eov, eco, es});
        tick();
    endtask

    // ------------------------------------------------------ compare process
    always @(negedge clk) begin
        if (rst) begin
            n_flushed += exp_q.size();
            exp_q.delete();
        end else begin
            if (w_out_valid && drv_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 64'(w_out_valid), 64'd0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    n_pop++;
                    check($sformatf("model_result_%0d", n_pop),
                          {30'd0, w_ovf, w_cout, w_sum}, {30'd0, e});
                end
            end
            if (w_in_ready && drv_valid) begin
                exp_q.push_back(model(width_of(sel), drv_a, drv_b, drv_cin));
                n_push++;
            end
        end
    end

    // ------------------------------------------------------------ watchdog
    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int lat;
        int seen;

        rst       = 1'b1;
        sel       = 0;
        drv_valid = 1'b0;
        drv_ready = 1'b1;
        drv_a     = '0;
        drv_b     = '0;
        drv_cin   = 1'b0;
        tick();
        tick();

        // Reset values on every instance.
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            check($sformatf("reset_state_%0d", k),
                  {28'd0, w_in_ready, w_out_valid, w_cout, w_ovf, w_sum},
                  {28'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0});
        end
        sel = 0;
        tick();
        rst = 1'b0;
        tick();

        // WIDTH=8 DIGIT=2: basic carries and signed overflow.
        run_op("ff_plus_01", 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 4);
        run_op("7f_plus_01", 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 4);
        run_op("80_plus_80", 32'h80, 32'h80, 1'b1, 32'h01, 1'b1, 1'b1, 4);

        // Back-pressure: result held, no accept while DONE.
        drv_ready = 1'b0;
        start_op(32'h3C, 32'h0F, 1'b0);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'd4);
        drv_a     = 32'h11;
        drv_b     = 32'h22;
        drv_cin   = 1'b0;
        drv_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_hold_%0d", i),
                  {29'd0, w_in_ready, w_out_valid, w_ovf, w_cout, w_sum},
                  {29'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4B});
            tick();
        end
        drv_ready = 1'b1;
        tick();
        check("bp_release", {62'd0, w_in_ready, w_out_valid}, {62'd0, 2'b10});
        run_op("after_bp", 32'h11, 32'h22, 1'b0, 32'h33, 1'b0, 1'b0, 4);

        // Reset two cycles after an accept aborts the operation.
        start_op(32'h12, 32'h34, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort", {62'd0, w_in_ready, w_out_valid}, {62'd0, 2'b10});
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (w_out_valid) seen++;
        end
        check("rst_no_out_valid", 64'(seen), 64'd0);
        run_op("after_rst", 32'h01, 32'h02, 1'b0, 32'h03, 1'b0, 1'b0, 4);

        // Digit-width extremes.
        sel = 1;
        run_op("d8_aa_55", 32'hAA, 32'h55, 1'b1, 32'h00, 1'b1, 1'b0, 1);
        sel = 2;
        run_op("d1_aa_55", 32'hAA, 32'h55, 1'b1, 32'h00, 1'b1, 1'b0, 8);

        // WIDTH=32 DIGIT=4 directed.
        sel = 3;
        run_op("w32_wrap", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 8);
        run_op("w32_ovf",  32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 8);

        // Random operands with random input gaps and random out_ready.
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    if (rnd_on) drv_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) tick();
            start_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        rnd_on = 1'b0;
        tick();
        drv_ready = 1'b1;
        for (int i = 0; i < 300 && (exp_q.size() != 0 || w_out_valid); i++) tick();
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("no_lost_or_dup", 64'(n_pop + n_flushed), 64'(n_push));
        check("every_issue_accepted", 64'(n_push), 64'(n_issued));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
